// File: rtl/io_pkg.sv
// Shared widths and types for the IO port slice.
// Consumed by io_port_if, io_fifo and io_port.
package io_pkg;

  localparam int IO_W          = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef logic [IO_W-1:0] io_byte_t;

  function automatic bit depth_ok(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/io_port_if.sv
// Register-file and device-side bundle of the IO port.
// slave faces io_port, master faces the surrounding system.
interface io_port_if;
  import io_pkg::*;

  logic     iow;
  io_byte_t ioout;
  logic     ior;
  io_byte_t ioin;

  io_byte_t tx_data;
  logic     tx_valid;
  logic     tx_ready;
  io_byte_t rx_data;
  logic     rx_valid;
  logic     rx_ready;

  logic     tx_full;
  logic     rx_full;
  logic [1:0] err;

  modport slave (
    input  iow, ioout, ior,
    input  tx_ready, rx_data, rx_valid,
    output ioin, tx_data, tx_valid,
    output rx_ready, tx_full, rx_full, err
  );

  modport master (
    output iow, ioout, ior,
    output tx_ready, rx_data, rx_valid,
    input  ioin, tx_data, tx_valid,
    input  rx_ready, tx_full, rx_full, err
  );

endinterface

// File: rtl/io_fifo.sv
// Circular TX FIFO with one extra pointer bit to tell full from empty.
// Caller guarantees no push when full without pop, no pop when empty.
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic     clk,
  input  logic     nclr,
  input  logic     push,
  input  logic     pop,
  input  io_byte_t din,
  output io_byte_t dout,
  output logic     empty,
  output logic     full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  io_byte_t    mem_q [DEPTH];
  io_byte_t    mem_d [DEPTH];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[wp_q[AW-1:0]] = din;
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/io_port.sv
// Byte IO port: TX storage toward a device, RX holding register back.
// Define IO_PORT_FIFO_EN for a DEPTH-entry TX FIFO instead of one register.
module io_port
  import io_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      nclr,
  io_port_if.slave  bus
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("io_port: DEPTH must be a power of 2, >= 2");
  end

  logic     pop;
  logic     push;
  logic     full;
  logic     empty;
  io_byte_t head;

  assign pop  = ~empty & bus.tx_ready;
  assign push = bus.iow & (~full | pop);

`ifdef IO_PORT_FIFO_EN
  io_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nclr  (nclr),
    .push  (push),
    .pop   (pop),
    .din   (bus.ioout),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );
`else
  io_byte_t hold_q, hold_d;
  logic     hv_q, hv_d;

  always_comb begin
    hold_d = hold_q;
    hv_d   = hv_q;
    if (push) begin
      hold_d = bus.ioout;
      hv_d   = 1'b1;
    end else if (pop) begin
      hv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      hold_q <= '0;
      hv_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hv_q   <= hv_d;
    end
  end

  assign head  = hold_q;
  assign empty = ~hv_q;
  assign full  = hv_q;
`endif

  // Stale FIFO contents never leak out while nothing is queued.
  assign bus.tx_data  = empty ? '0 : head;
  assign bus.tx_valid = ~empty;
  assign bus.tx_full  = full;

  logic       rx_full_q, rx_full_d;
  io_byte_t   ioin_q, ioin_d;
  logic [1:0] err_q, err_d;

  always_comb begin
    rx_full_d = rx_full_q;
    ioin_d    = ioin_q;
    err_d     = err_q;
    if (bus.rx_valid && !rx_full_q) begin
      ioin_d    = bus.rx_data;
      rx_full_d = 1'b1;
    end
    if (bus.ior) begin
      if (rx_full_q) rx_full_d = 1'b0;
      else           err_d[1]  = 1'b1;
    end
    if (bus.iow && full && !pop) begin
      err_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      rx_full_q <= 1'b0;
      ioin_q    <= '0;
      err_q     <= '0;
    end else begin
      rx_full_q <= rx_full_d;
      ioin_q    <= ioin_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_full  = rx_full_q;
  assign bus.rx_ready = ~rx_full_q;
  assign bus.ioin     = ioin_q;
  assign bus.err      = err_q;

endmodule
